// File: rtl/fetch_align.sv
// RV32IC fetch aligner: word reads from instruction memory into a 3-entry halfword
// queue, one whole (16- or 32-bit) instruction per handshake toward decode.
module fetch_align #(
    parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_address,
    output logic        imem_read,
    input  logic [31:0] imem_rdata,
    input  logic        imem_resp,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_ir,
    output logic [31:0] out_pc,
    output logic        out_compressed
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_REQ     = 2'd1;
    localparam logic [1:0] S_DISCARD = 2'd2;

    logic [1:0]  st;
    logic [15:0] q    [3];
    logic [15:0] q_nx [3];
    logic [1:0]  cnt, cnt_nx, base;
    logic [31:0] pc, fetch_addr, req_addr;
    logic        skip_low;

    logic        head_c, complete, load, accept;
    logic [1:0]  pop, push;
    logic [15:0] push_lo;

    assign head_c   = q[0][1:0] != 2'b11;
    assign complete = (cnt >= 2'd1 && head_c) || cnt >= 2'd2;
    assign load     = (!out_valid || out_ready) && complete && !redirect;
    assign pop      = load ? (head_c ? 2'd1 : 2'd2) : 2'd0;
    assign accept   = st == S_REQ && imem_resp && !redirect;
    assign push     = accept ? (skip_low ? 2'd1 : 2'd2) : 2'd0;
    assign push_lo  = skip_low ? imem_rdata[31:16] : imem_rdata[15:0];

    // A read is offered straight from IDLE so back-to-back fetches lose no cycle;
    // once in REQ/DISCARD the captured address is held until the response.
    assign imem_read    = rst_n && (st != S_IDLE || (cnt <= 2'd1 && !redirect));
    assign imem_address = (st == S_IDLE) ? fetch_addr : req_addr;

    always_comb begin
        base = cnt - pop;
        case (pop)
            2'd1:    q_nx = '{q[1], q[2], q[2]};
            2'd2:    q_nx = '{q[2], q[2], q[2]};
            default: q_nx = q;
        endcase
        for (int i = 0; i < 3; i++) begin
            if (push != 2'd0 && base == 2'(i))
                q_nx[i] = push_lo;
            if (push == 2'd2 && base + 2'd1 == 2'(i))
                q_nx[i] = imem_rdata[31:16];
        end
        cnt_nx = cnt - pop + push;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q          <= '{default: 16'h0};
            cnt        <= 2'd0;
            pc         <= {RESET_PC[31:1], 1'b0};
            fetch_addr <= {RESET_PC[31:2], 2'b00};
            skip_low   <= RESET_PC[1];
        end else if (redirect) begin
            cnt        <= 2'd0;
            pc         <= {redirect_pc[31:1], 1'b0};
            fetch_addr <= {redirect_pc[31:2], 2'b00};
            skip_low   <= redirect_pc[1];
        end else begin
            q   <= q_nx;
            cnt <= cnt_nx;
            if (load)
                pc <= pc + (head_c ? 32'd2 : 32'd4);
            if (accept) begin
                fetch_addr <= fetch_addr + 32'd4;
                skip_low   <= 1'b0;
            end
        end
    end

    // Redirect while a read is in flight must still wait out that response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st       <= S_IDLE;
            req_addr <= 32'h0;
        end else begin
            case (st)
                S_IDLE: if (!redirect && cnt <= 2'd1) begin
                    st       <= S_REQ;
                    req_addr <= fetch_addr;
                end
                S_REQ: begin
                    if (imem_resp)
                        st <= S_IDLE;
                    else if (redirect)
                        st <= S_DISCARD;
                end
                S_DISCARD: if (imem_resp) st <= S_IDLE;
                default: st <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid      <= 1'b0;
            out_ir         <= 32'h0;
            out_pc         <= 32'h0;
            out_compressed <= 1'b0;
        end else if (redirect) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid      <= 1'b1;
            out_ir         <= head_c ? {16'h0, q[0]} : {q[1], q[0]};
            out_pc         <= pc;
            out_compressed <= head_c;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fetch_align.sv
// Directed bench for fetch_align: latency-controlled memory model, output log, scenario tasks.
module tb_fetch_align;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] imem_address;
    logic        imem_read;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_ir;
    logic [31:0] out_pc;
    logic        out_compressed;

    fetch_align #(.RESET_PC(32'h0000_0060)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_address(imem_address), .imem_read(imem_read),
        .imem_rdata(imem_rdata), .imem_resp(imem_resp),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_ir(out_ir),
        .out_pc(out_pc), .out_compressed(out_compressed)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ir;
        logic        c;
        int          cyc;
    } out_t;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] rd_log [$];
    out_t        outs [$];
    int          mem_lat = 0;
    int          cyc = 0;
    int          pass = 0;
    int          total = 0;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'h0001_0001;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Memory responds mem_lat cycles after the read has been seen across one edge.
    initial begin
        int age;
        age = 0;
        imem_resp = 1'b0;
        imem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            imem_resp = 1'b0;
            if (!rst_n || !imem_read) begin
                age = 0;
            end else if (age >= mem_lat + 1) begin
                imem_resp = 1'b1;
                imem_rdata = mem_rd(imem_address);
                rd_log.push_back(imem_address);
                age = 0;
            end else begin
                age++;
            end
        end
    end

    initial begin
        out_t o;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                o.pc = out_pc; o.ir = out_ir; o.c = out_compressed; o.cyc = cyc;
                outs.push_back(o);
            end
        end
    end

    task automatic do_reset(input logic rdy);
        rst_n = 1'b0;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        out_ready = rdy;
        repeat (2) @(posedge clk);
        outs.delete();
        rd_log.delete();
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_outs(input int n);
        int k;
        k = 0;
        while (outs.size() < n && k < 300) begin
            @(posedge clk);
            k++;
        end
        total++;
        if (outs.size() < n) $display("FAIL wait_outs: got %0d outputs, want %0d", outs.size(), n);
        else pass++;
    endtask

    task automatic wait_valid();
        int k;
        k = 0;
        while (out_valid !== 1'b1 && k < 300) begin
            @(posedge clk);
            #1;
            k++;
        end
        total++;
        if (out_valid !== 1'b1) $display("FAIL wait_valid: out_valid=%b, want 1", out_valid);
        else pass++;
    endtask

    task automatic test_reset();
        mem.delete();
        mem[32'h60] = 32'h00a0_0093;
        mem_lat = 0;
        rst_n = 1'b1; #2;
        rst_n = 1'b0; #1;
        total++;
        if ({imem_read, out_valid, out_compressed} !== 3'b000 || out_ir !== 32'h0 || out_pc !== 32'h0)
            $display("FAIL reset_outputs: read=%b valid=%b c=%b ir=%h pc=%h, want all 0",
                     imem_read, out_valid, out_compressed, out_ir, out_pc);
        else pass++;
        do_reset(1'b1);
        #1;
        total++;
        if (imem_read !== 1'b1 || imem_address !== 32'h60)
            $display("FAIL first_read: read=%b addr=%h, want 1 00000060", imem_read, imem_address);
        else pass++;
        @(posedge clk); #1;
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b0) $display("FAIL latency_early: out_valid=%b, want 0", out_valid);
        else pass++;
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b1 || out_pc !== 32'h60 || out_ir !== 32'h00a00093 || out_compressed !== 1'b0)
            $display("FAIL first_out: v=%b pc=%h ir=%h c=%b, want 1 00000060 00a00093 0",
                     out_valid, out_pc, out_ir, out_compressed);
        else pass++;
        repeat (4) @(posedge clk);
        total++;
        if (rd_log.size() < 2 || rd_log[1] !== 32'h64)
            $display("FAIL second_read: log size %0d addr %h, want 00000064", rd_log.size(),
                     (rd_log.size() > 1) ? rd_log[1] : 32'hffff_ffff);
        else pass++;
    endtask

    task automatic test_compressed_pair();
        mem.delete();
        mem[32'h60] = 32'h0001_0001;
        mem[32'h64] = 32'h0002_0002;
        mem_lat = 0;
        do_reset(1'b1);
        wait_outs(3);
        total++;
        if (outs[0].pc !== 32'h60 || outs[0].ir !== 32'h1 || outs[0].c !== 1'b1)
            $display("FAIL cpair_0: pc=%h ir=%h c=%b, want 00000060 00000001 1", outs[0].pc, outs[0].ir, outs[0].c);
        else pass++;
        total++;
        if (outs[1].pc !== 32'h62 || outs[1].ir !== 32'h1 || outs[1].c !== 1'b1)
            $display("FAIL cpair_1: pc=%h ir=%h c=%b, want 00000062 00000001 1", outs[1].pc, outs[1].ir, outs[1].c);
        else pass++;
        total++;
        if (outs[1].cyc !== outs[0].cyc + 1)
            $display("FAIL cpair_b2b: second at cycle %0d, want %0d", outs[1].cyc, outs[0].cyc + 1);
        else pass++;
        total++;
        if (outs[2].pc !== 32'h64 || outs[2].ir !== 32'h2)
            $display("FAIL cpair_2: pc=%h ir=%h, want 00000064 00000002", outs[2].pc, outs[2].ir);
        else pass++;
    endtask

    task automatic test_straddle();
        mem.delete();
        mem[32'h60] = 32'h0093_0001;
        mem[32'h64] = 32'hABCD_00a0;
        mem_lat = 1;
        do_reset(1'b1);
        wait_outs(3);
        total++;
        if (outs[0].pc !== 32'h60 || outs[0].ir !== 32'h1 || outs[0].c !== 1'b1)
            $display("FAIL straddle_0: pc=%h ir=%h c=%b, want 00000060 00000001 1", outs[0].pc, outs[0].ir, outs[0].c);
        else pass++;
        total++;
        if (outs[1].pc !== 32'h62 || outs[1].ir !== 32'h00a00093 || outs[1].c !== 1'b0)
            $display("FAIL straddle_1: pc=%h ir=%h c=%b, want 00000062 00a00093 0", outs[1].pc, outs[1].ir, outs[1].c);
        else pass++;
        total++;
        if (outs[2].pc !== 32'h66 || outs[2].ir !== 32'h0000ABCD || outs[2].c !== 1'b1)
            $display("FAIL straddle_2: pc=%h ir=%h c=%b, want 00000066 0000abcd 1", outs[2].pc, outs[2].ir, outs[2].c);
        else pass++;
    endtask

    task automatic test_redirect();
        mem.delete();
        mem[32'h60]  = 32'h00a0_0093;
        mem[32'h64]  = 32'h1234_5677;
        mem[32'h100] = 32'h0005_0009;
        mem_lat = 3;
        do_reset(1'b1);
        wait_valid();
        @(posedge clk); #1;
        redirect = 1'b1;
        redirect_pc = 32'h102;
        @(posedge clk); #1;
        redirect = 1'b0;
        total++;
        if (out_valid !== 1'b0) $display("FAIL redir_flush: out_valid=%b, want 0", out_valid);
        else pass++;
        for (int i = 0; i < 2; i++) begin
            total++;
            if (imem_read !== 1'b1 || imem_address !== 32'h64)
                $display("FAIL redir_hold: read=%b addr=%h, want 1 00000064", imem_read, imem_address);
            else pass++;
            @(posedge clk); #1;
        end
        wait_outs(2);
        total++;
        if (outs[0].pc !== 32'h60 || outs[1].pc !== 32'h102 || outs[1].ir !== 32'h5 || outs[1].c !== 1'b1)
            $display("FAIL redir_out: pc0=%h pc1=%h ir1=%h c1=%b, want 00000060 00000102 00000005 1",
                     outs[0].pc, outs[1].pc, outs[1].ir, outs[1].c);
        else pass++;
        total++;
        if (rd_log.size() < 3 || rd_log[2] !== 32'h100)
            $display("FAIL redir_read: log size %0d third addr %h, want 00000100", rd_log.size(),
                     (rd_log.size() > 2) ? rd_log[2] : 32'hffff_ffff);
        else pass++;
    endtask

    task automatic test_stall();
        logic [31:0] exp_ir [5];
        logic [31:0] p0, i0;
        exp_ir = '{32'h00a00093, 32'h00b00113, 32'h00c00193, 32'h00d00213, 32'h00e00293};
        mem.delete();
        for (int i = 0; i < 5; i++) mem[32'h60 + 32'(4 * i)] = exp_ir[i];
        mem_lat = 0;
        do_reset(1'b0);
        wait_valid();
        p0 = out_pc;
        i0 = out_ir;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            total++;
            if (out_valid !== 1'b1 || out_pc !== p0 || out_ir !== i0 || p0 !== 32'h60)
                $display("FAIL stall_hold: v=%b pc=%h ir=%h, want 1 00000060 %h", out_valid, out_pc, out_ir, i0);
            else pass++;
        end
        total++;
        if (rd_log.size() > 2) $display("FAIL stall_reads: %0d reads, want <= 2", rd_log.size());
        else pass++;
        out_ready = 1'b1;
        wait_outs(5);
        for (int i = 0; i < 5; i++) begin
            total++;
            if (outs[i].pc !== 32'h60 + 32'(4 * i) || outs[i].ir !== exp_ir[i] || outs[i].c !== 1'b0)
                $display("FAIL stall_order%0d: pc=%h ir=%h, want %h %h", i, outs[i].pc, outs[i].ir,
                         32'h60 + 32'(4 * i), exp_ir[i]);
            else pass++;
        end
    endtask

    task automatic test_async_reset();
        mem.delete();
        mem[32'h60] = 32'h00a0_0093;
        mem_lat = 4;
        do_reset(1'b0);
        wait_valid();
        @(posedge clk); #1;
        total++;
        if (imem_read !== 1'b1 || out_valid !== 1'b1)
            $display("FAIL arst_pre: read=%b valid=%b, want 1 1", imem_read, out_valid);
        else pass++;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (imem_read !== 1'b0 || out_valid !== 1'b0 || out_pc !== 32'h0)
            $display("FAIL arst_drop: read=%b valid=%b pc=%h, want 0 0 00000000", imem_read, out_valid, out_pc);
        else pass++;
        mem_lat = 0;
        do_reset(1'b1);
        #1;
        total++;
        if (imem_read !== 1'b1 || imem_address !== 32'h60)
            $display("FAIL arst_restart: read=%b addr=%h, want 1 00000060", imem_read, imem_address);
        else pass++;
        wait_outs(1);
        total++;
        if (outs[0].pc !== 32'h60 || outs[0].ir !== 32'h00a00093)
            $display("FAIL arst_out: pc=%h ir=%h, want 00000060 00a00093", outs[0].pc, outs[0].ir);
        else pass++;
    endtask

    initial begin
        redirect = 1'b0;
        redirect_pc = 32'h0;
        out_ready = 1'b0;
        test_reset();
        test_compressed_pair();
        test_straddle();
        test_redirect();
        test_stall();
        test_async_reset();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule

// File: doc/fetch_align.md
# fetch_align

Instruction fetch aligner for the RV32IC pipeline, placed between the instruction cache port and the decode stage. It issues word-aligned reads to instruction memory and buffers the returned halfwords. It delivers one whole instruction per handshake to decode, either 16-bit compressed or 32-bit, at any halfword-aligned PC. Compressed instructions are passed through unexpanded; decode performs the expansion.

## Interface
Parameters:
- RESET_PC, 32'h00000060, first instruction address after reset; must be halfword aligned.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- imem_address  out  32  word-aligned fetch address; bits [1:0] are always 0.
- imem_read  out  1  read request; held high with a stable address until imem_resp.
- imem_rdata  in  32  returned word; sampled only when imem_resp is high.
- imem_resp  in  1  one-cycle completion of the outstanding read.
- redirect  in  1  flush and restart fetch at redirect_pc (taken branch or jump).
- redirect_pc  in  32  new PC; bit 0 is ignored.
- out_valid  out  1  out_ir, out_pc and out_compressed hold a valid instruction.
- out_ready  in  1  decode accepts the instruction this cycle.
- out_ir  out  32  instruction. A compressed instruction appears as {16'h0, half}.
- out_pc  out  32  address of out_ir.
- out_compressed  out  1  out_ir is a 16-bit instruction.

## Operation
- State:
  - halfword queue: depth 3, 16 bits per entry, count 0..3.
  - pc: address of the queue head.
  - fetch_addr: word-aligned address of the next read.
  - skip_low flag.
  - memory FSM: IDLE, REQ, DISCARD.
  - output register.
- Length rule: the head halfword is compressed iff bits [1:0] != 2'b11.
- A complete instruction is present when count >= 1 and the head is compressed, or when count >= 2.
- Memory FSM:
  - IDLE -> REQ when count <= 1 and there is no redirect. imem_read = 1, imem_address = fetch_addr.
  - REQ, on imem_resp:
    - Push rdata[15:0] then rdata[31:16], oldest first.
    - If skip_low is set, push only rdata[31:16] and clear skip_low.
    - fetch_addr += 4.
    - Return to IDLE.
  - REQ with redirect and no imem_resp -> DISCARD. imem_read stays high with the old address.
  - DISCARD, on imem_resp: drop the data and go to IDLE.
- Emit: the output register loads when (!out_valid || out_ready), a complete instruction is present, and there is no redirect.
  - Compressed head: out_ir = {16'h0, head}, pop 1, pc += 2.
  - 32-bit head: out_ir = {entry1, head}, pop 2, pc += 4.
  - A handshake with nothing new to load clears out_valid.
- Redirect (takes priority over everything else):
  - Clears the queue and out_valid.
  - pc = {redirect_pc[31:1], 1'b0}.
  - fetch_addr = {redirect_pc[31:2], 2'b00}.
  - skip_low = redirect_pc[1].
  - Any handshake in the redirect cycle still counts as consumed by decode.
  - Redirect and imem_resp in the same REQ cycle: the data is dropped and the FSM goes to IDLE, not DISCARD.
- The queue never overflows. A read is issued only when count <= 1, count only decreases while a read is outstanding, and a push is at most 2 entries.
- Wrap-around: pc and fetch_addr wrap modulo 2^32.

## Timing
- Reset values:
  - out_valid = 0, out_ir = 0, out_pc = 0, out_compressed = 0.
  - imem_read = 0, FSM = IDLE, count = 0.
  - pc = RESET_PC, fetch_addr = {RESET_PC[31:2], 2'b00}, skip_low = RESET_PC[1].
- Outputs clear immediately when rst_n falls, including mid-request. The memory side must tolerate a dropped request.
- First imem_read: asserted in the first cycle after rst_n deasserts.
- Latency: imem_resp in cycle t -> out_valid in cycle t+2 (queue write, then output-register load), provided the output register is free.
- Back-to-back reads: the next imem_read is asserted in cycle t+1 if count <= 1 after cycle t's push and pop.
- Throughput: one instruction per cycle while the queue holds complete instructions and out_ready = 1.
- Output stability: while out_valid && !out_ready, out_ir, out_pc and out_compressed stay stable.
- Redirect in cycle t:
  - out_valid = 0 in cycle t+1.
  - From IDLE or REQ+resp: imem_read with the new address in cycle t+1.
  - From DISCARD: imem_read with the new address in the cycle after the discarded resp.

## Test plan
- Reset with RESET_PC = 0x60, word@0x60 = 0x00a00093 -> read 0x60, then out_pc = 0x60, out_ir = 0x00a00093, out_compressed = 0. The next read is to 0x64.
- Word@0x60 = 0x00010001 with out_ready = 1 -> two consecutive outputs, pc 0x60 then 0x62, each out_ir = 0x00000001 with out_compressed = 1. Only one read covers both.
- Word@0x60 = 0x00930001 and word@0x64 = 0xXXXX00a0 -> outputs pc 0x60 (c.nop), then pc 0x62 with out_ir = 0x00a00093 and out_compressed = 0.
- redirect_pc = 0x102 while the read to 0x64 is outstanding and unresolved for 3 cycles -> imem_read stays high at 0x64 until resp, and that data never appears at the output. The next read is to 0x100, the low half is dropped, and the first out_pc = 0x102.
- out_ready low for 5 cycles with a stream of 32-bit instructions -> outputs are held stable, at most one extra word is fetched, and all instructions are delivered in order afterwards.
- rst_n pulled low while imem_read = 1 and out_valid = 1 -> both drop without a clock edge. After release, fetch restarts at RESET_PC.
